// File: rtl/draw_bg_anim_if.sv
// vga_if: VGA timing bundle shared by the pipeline stages (11-bit counters, 12-bit rgb).
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_bg_anim.sv
// draw_bg_anim: 2-stage animated background (SOLID / RADIAL / RADIAL_ANIM / CHECKER).
// Define DRAW_BG_ANIM_EN to enable the per-frame phase counter that scrolls RADIAL_ANIM.
module draw_bg_anim #(
  parameter int unsigned X_C        = 220,
  parameter int unsigned Y_C        = 240,
  parameter logic [11:0] BASE_RGB   = 12'h79A,
  parameter int unsigned SHIFT_R    = 2,
  parameter int unsigned SHIFT_G    = 2,
  parameter int unsigned SHIFT_B    = 3,
  parameter int unsigned RING_LSB   = 13,
  parameter int unsigned PHASE_STEP = 1,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic       clk,
  input  logic       rst,
  vga_if.in          in,
  vga_if.out         out,
  input  logic [1:0] mode_req,
  input  logic       pause
);

  localparam logic [1:0] MODE_SOLID       = 2'd0;
  localparam logic [1:0] MODE_RADIAL      = 2'd1;
  localparam logic [1:0] MODE_RADIAL_ANIM = 2'd2;
  localparam logic [1:0] MODE_CHECKER     = 2'd3;

  function automatic logic [3:0] sat_add(input logic [3:0] base, input logic [3:0] inc);
    logic [4:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    return sum[4] ? 4'hF : sum[3:0];
  endfunction

  logic [11:0] unused_rgb;
  assign unused_rgb = in.rgb;

  // frame start detection and per-frame mode latch
  logic       vblnk_prev_q, vblnk_prev_d;
  logic [1:0] mode_q, mode_d;
  logic       fs;
  logic [3:0] phase;

  always_comb begin
    fs           = in.vblnk & ~vblnk_prev_q;
    vblnk_prev_d = in.vblnk;
    mode_d       = fs ? mode_req : mode_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      mode_q       <= MODE_SOLID;
    end else begin
      vblnk_prev_q <= vblnk_prev_d;
      mode_q       <= mode_d;
    end
  end

`ifdef DRAW_BG_ANIM_EN
  logic [3:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (fs && !pause) phase_d = phase_q + 4'(PHASE_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

  assign phase = phase_q;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign phase        = '0;
`endif

  // stage 1: distance from ring centre, checker bit, timing
  logic signed [11:0] dx, dy;
  logic signed [23:0] dx_w, dy_w;
  logic [23:0] s1_dist_q, s1_dist_d;
  logic        s1_chk_q, s1_chk_d;
  logic [10:0] s1_hcount_q, s1_vcount_q;
  logic        s1_hsync_q, s1_vsync_q, s1_hblnk_q, s1_vblnk_q;

  always_comb begin
    dx        = 12'({1'b0, in.hcount}) - 12'(X_C);
    dy        = 12'({1'b0, in.vcount}) - 12'(Y_C);
    dx_w      = 24'(dx);
    dy_w      = 24'(dy);
    // both squares are non-negative and their sum stays below 2^24
    s1_dist_d = dx_w * dx_w + dy_w * dy_w;
    s1_chk_d  = in.hcount[CHECK_LOG2] ^ in.vcount[CHECK_LOG2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_dist_q   <= '0;
      s1_chk_q    <= 1'b0;
      s1_hcount_q <= '0;
      s1_vcount_q <= '0;
      s1_hsync_q  <= 1'b0;
      s1_vsync_q  <= 1'b0;
      s1_hblnk_q  <= 1'b0;
      s1_vblnk_q  <= 1'b0;
    end else begin
      s1_dist_q   <= s1_dist_d;
      s1_chk_q    <= s1_chk_d;
      s1_hcount_q <= in.hcount;
      s1_vcount_q <= in.vcount;
      s1_hsync_q  <= in.hsync;
      s1_vsync_q  <= in.vsync;
      s1_hblnk_q  <= in.hblnk;
      s1_vblnk_q  <= in.vblnk;
    end
  end

  // stage 2: band select and saturated colour
  logic [3:0]  band;
  logic [3:0]  ring;
  logic [11:0] out_rgb_q, out_rgb_d;
  logic [10:0] out_hcount_q, out_vcount_q;
  logic        out_hsync_q, out_vsync_q, out_hblnk_q, out_vblnk_q;

  always_comb begin
    ring = s1_dist_q[RING_LSB +: 4];
    case (mode_q)
      MODE_RADIAL:      band = ring;
      MODE_RADIAL_ANIM: band = ring + phase;
      MODE_CHECKER:     band = s1_chk_q ? 4'hF : 4'h0;
      default:          band = 4'h0;
    endcase
    out_rgb_d = {sat_add(BASE_RGB[11:8], band >> SHIFT_R),
                 sat_add(BASE_RGB[7:4],  band >> SHIFT_G),
                 sat_add(BASE_RGB[3:0],  band >> SHIFT_B)};
    if (s1_vblnk_q || s1_hblnk_q) out_rgb_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_rgb_q    <= '0;
      out_hcount_q <= '0;
      out_vcount_q <= '0;
      out_hsync_q  <= 1'b0;
      out_vsync_q  <= 1'b0;
      out_hblnk_q  <= 1'b0;
      out_vblnk_q  <= 1'b0;
    end else begin
      out_rgb_q    <= out_rgb_d;
      out_hcount_q <= s1_hcount_q;
      out_vcount_q <= s1_vcount_q;
      out_hsync_q  <= s1_hsync_q;
      out_vsync_q  <= s1_vsync_q;
      out_hblnk_q  <= s1_hblnk_q;
      out_vblnk_q  <= s1_vblnk_q;
    end
  end

  assign out.rgb    = out_rgb_q;
  assign out.hcount = out_hcount_q;
  assign out.vcount = out_vcount_q;
  assign out.hsync  = out_hsync_q;
  assign out.vsync  = out_vsync_q;
  assign out.hblnk  = out_hblnk_q;
  assign out.vblnk  = out_vblnk_q;

endmodule

// File: tb/tb_draw_bg_anim.sv
// Directed bench for draw_bg_anim: default instance (BASE 79A) plus a BASE EEE instance for saturation.
module tb_draw_bg_anim;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode_req;
  logic       pause;

  int unsigned errors = 0;
  int unsigned checks = 0;

  vga_if vin ();
  vga_if vout1 ();
  vga_if vout2 ();

  always #5 clk = ~clk;

  draw_bg_anim u_dut (
    .clk      (clk),
    .rst      (rst),
    .in       (vin),
    .out      (vout1),
    .mode_req (mode_req),
    .pause    (pause)
  );

  draw_bg_anim #(.BASE_RGB(12'hEEE)) u_dut_sat (
    .clk      (clk),
    .rst      (rst),
    .in       (vin),
    .out      (vout2),
    .mode_req (mode_req),
    .pause    (pause)
  );

`ifdef DRAW_BG_ANIM_EN
  localparam logic [11:0] P8_C1 = 12'h9BB, P8_C2 = 12'hFFF;   // (220,240) at phase 8
  localparam logic [11:0] P8_R1 = 12'h79A, P8_R2 = 12'hEEE;   // (476,240) at phase 8
  localparam logic [11:0] P5_C1 = 12'h8AA, P5_C2 = 12'hFFE;   // (220,240) at phase 5
`else
  localparam logic [11:0] P8_C1 = 12'h79A, P8_C2 = 12'hEEE;
  localparam logic [11:0] P8_R1 = 12'h9BB, P8_R2 = 12'hFFF;
  localparam logic [11:0] P5_C1 = 12'h79A, P5_C2 = 12'hEEE;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input logic hb, input logic vb,
                       input logic hs, input logic vs);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.rgb    = 12'h5A5;
  endtask

  // Pixel is held for exactly one cycle, then replaced, so only a 2-cycle latency lines up.
  task automatic pix_chk(input string tag, input int h, input int v, input logic hb,
                         input logic hs, input logic vs,
                         input logic [11:0] exp1, input logic [11:0] exp2);
    drive(h, v, hb, 1'b0, hs, vs);
    @(posedge clk); #1;
    drive(7, 3, 1'b1, 1'b0, ~hs, ~vs);
    @(posedge clk); #1;
    check({tag, ".rgb"},    32'(vout1.rgb),    32'(exp1));
    check({tag, ".rgb_sat"},32'(vout2.rgb),    32'(exp2));
    check({tag, ".hcount"}, 32'(vout1.hcount), 32'(h));
    check({tag, ".vcount"}, 32'(vout1.vcount), 32'(v));
    check({tag, ".hsync"},  32'(vout1.hsync),  32'(hs));
    check({tag, ".vsync"},  32'(vout1.vsync),  32'(vs));
    check({tag, ".hblnk"},  32'(vout1.hblnk),  32'(hb));
  endtask

  task automatic frame_start();
    drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("fs.vblnk", 32'(vout1.vblnk), 32'd1);
    check("fs.rgb",   32'(vout1.rgb),   32'd0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame_start();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rgb"},     32'(vout1.rgb),    32'd0);
    check({tag, ".rgb_sat"}, 32'(vout2.rgb),    32'd0);
    check({tag, ".hcount"},  32'(vout1.hcount), 32'd0);
    check({tag, ".vcount"},  32'(vout1.vcount), 32'd0);
    check({tag, ".hsync"},   32'(vout1.hsync),  32'd0);
    check({tag, ".vsync"},   32'(vout1.vsync),  32'd0);
    check({tag, ".hblnk"},   32'(vout1.hblnk),  32'd0);
    check({tag, ".vblnk"},   32'(vout1.vblnk),  32'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    mode_req = 2'd0;
    pause    = 1'b0;
    drive(5, 6, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    pix_chk("solid_after_rst", 476, 240, 1'b0, 1'b1, 1'b0, 12'h79A, 12'hEEE);

    // RADIAL
    mode_req = 2'd1;
    frame_start();
    pix_chk("radial_centre", 220, 240, 1'b0, 1'b0, 1'b0, 12'h79A, 12'hEEE);
    pix_chk("radial_band8",  476, 240, 1'b0, 1'b1, 1'b0, 12'h9BB, 12'hFFF);
    pix_chk("radial_band15", 571, 240, 1'b0, 1'b0, 1'b1, 12'hACB, 12'hFFF);
    pix_chk("radial_hblnk",  476, 240, 1'b1, 1'b1, 1'b1, 12'h000, 12'h000);

    // mode request mid-frame is ignored until the next frame start
    mode_req = 2'd3;
    pix_chk("latch_hold",    571, 240, 1'b0, 1'b0, 1'b0, 12'hACB, 12'hFFF);
    frame_start();
    pix_chk("checker_32_0",  32,  0,   1'b0, 1'b0, 1'b0, 12'hACB, 12'hFFF);
    pix_chk("checker_0_0",   0,   0,   1'b0, 1'b0, 1'b0, 12'h79A, 12'hEEE);
    pix_chk("checker_571",   571, 240, 1'b0, 1'b0, 1'b0, 12'h79A, 12'hEEE);

    // RADIAL_ANIM: phase has advanced once per frame start so far (3 after this one)
    mode_req = 2'd2;
    frame_start();
    pix_chk("anim_p3",       220, 240, 1'b0, 1'b0, 1'b0, 12'h79A, 12'hEEE);
    frames(5);
    pix_chk("anim_p8_c",     220, 240, 1'b0, 1'b0, 1'b0, P8_C1, P8_C2);
    pix_chk("anim_p8_r",     476, 240, 1'b0, 1'b0, 1'b0, P8_R1, P8_R2);
    frames(8);
    pix_chk("anim_wrap_c",   220, 240, 1'b0, 1'b0, 1'b0, 12'h79A, 12'hEEE);
    pix_chk("anim_wrap_r",   476, 240, 1'b0, 1'b0, 1'b0, 12'h9BB, 12'hFFF);

    // pause: phase frozen, mode still latched on frame start
    pause = 1'b1;
    frames(3);
    mode_req = 2'd3;
    frame_start();
    pix_chk("pause_mode_chk", 32,  0,   1'b0, 1'b0, 1'b0, 12'hACB, 12'hFFF);
    pix_chk("pause_chk_220",  220, 240, 1'b0, 1'b0, 1'b0, 12'hACB, 12'hFFF);
    mode_req = 2'd2;
    frame_start();
    pix_chk("pause_phase0",   220, 240, 1'b0, 1'b0, 1'b0, 12'h79A, 12'hEEE);
    pause = 1'b0;
    frames(5);
    pix_chk("anim_p5",        220, 240, 1'b0, 1'b0, 1'b0, P5_C1, P5_C2);

    // reset mid-frame
    drive(220, 240, 1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    rst = 1'b0;
    pix_chk("midrst_solid_c", 220, 240, 1'b0, 1'b0, 1'b0, 12'h79A, 12'hEEE);
    pix_chk("midrst_solid_r", 476, 240, 1'b0, 1'b0, 1'b0, 12'h79A, 12'hEEE);
    mode_req = 2'd2;
    frame_start();
    pix_chk("midrst_phase1",  220, 240, 1'b0, 1'b0, 1'b0, 12'h79A, 12'hEEE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
